// File: rtl/e203_exu_disp_oitf.sv
// Dispatch stage with an in-order outstanding-instruction tracking FIFO.
// Blocks on RAW/WAW hazards against long-pipe entries and serialises CSR/fence.
module e203_exu_disp_oitf #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int PC_SIZE = 32,
  parameter int INFO_W  = 32,
  parameter int DEPTH   = 4,
  localparam int ITAG_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wfi_halt_exu_req,
  output logic               wfi_halt_exu_ack,
  input  logic               amo_wait,
  input  logic               disp_i_valid,
  output logic               disp_i_ready,
  input  logic               disp_i_rs1en,
  input  logic               disp_i_rs2en,
  input  logic               disp_i_rs1x0,
  input  logic               disp_i_rs2x0,
  input  logic [RFIDX_W-1:0] disp_i_rs1idx,
  input  logic [RFIDX_W-1:0] disp_i_rs2idx,
  input  logic [RFIDX_W-1:0] disp_i_rdidx,
  input  logic [XLEN-1:0]    disp_i_rs1,
  input  logic [XLEN-1:0]    disp_i_rs2,
  input  logic [XLEN-1:0]    disp_i_imm,
  input  logic               disp_i_rdwen,
  input  logic [INFO_W-1:0]  disp_i_info,
  input  logic [PC_SIZE-1:0] disp_i_pc,
  input  logic               disp_i_csr,
  input  logic               disp_i_fence,
  input  logic               disp_i_longp,
  output logic               disp_o_alu_valid,
  input  logic               disp_o_alu_ready,
  input  logic               disp_o_alu_longpipe,
  output logic [XLEN-1:0]    disp_o_alu_rs1,
  output logic [XLEN-1:0]    disp_o_alu_rs2,
  output logic [XLEN-1:0]    disp_o_alu_imm,
  output logic               disp_o_alu_rdwen,
  output logic [RFIDX_W-1:0] disp_o_alu_rdidx,
  output logic [INFO_W-1:0]  disp_o_alu_info,
  output logic [PC_SIZE-1:0] disp_o_alu_pc,
  output logic [ITAG_W-1:0]  disp_o_alu_itag,
  input  logic               oitf_ret_ena,
  output logic               oitf_ret_rdwen,
  output logic [RFIDX_W-1:0] oitf_ret_rdidx,
  output logic [PC_SIZE-1:0] oitf_ret_pc,
  output logic [ITAG_W-1:0]  oitf_ret_itag,
  output logic               oitf_empty,
  output logic               oitf_full
);

  // Pointer MSB is the wrap flag that separates full from empty.
  logic [ITAG_W:0]      alc_ptr, ret_ptr;
  logic [ITAG_W-1:0]    alc_idx, ret_idx;
  logic [DEPTH-1:0]     ent_vld, ent_rdwen;
  logic [RFIDX_W-1:0]   ent_rdidx [DEPTH];
  logic [PC_SIZE-1:0]   ent_pc    [DEPTH];
  logic                 raw, waw, cond, alc_ena, ret_ena;

  assign alc_idx    = alc_ptr[ITAG_W-1:0];
  assign ret_idx    = ret_ptr[ITAG_W-1:0];
  assign oitf_empty = (alc_ptr == ret_ptr);
  assign oitf_full  = (alc_ptr[ITAG_W] != ret_ptr[ITAG_W]) && (alc_idx == ret_idx);

  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld[k] && ent_rdwen[k]) begin
        if (disp_i_rs1en && !disp_i_rs1x0 && (ent_rdidx[k] == disp_i_rs1idx)) raw = 1'b1;
        if (disp_i_rs2en && !disp_i_rs2x0 && (ent_rdidx[k] == disp_i_rs2idx)) raw = 1'b1;
        if (disp_i_rdwen && (ent_rdidx[k] == disp_i_rdidx)) waw = 1'b1;
      end
    end
  end

  assign cond = !wfi_halt_exu_req && !raw && !waw
              && (!disp_i_csr   || oitf_empty)
              && (!disp_i_fence || oitf_empty)
              && (!disp_i_longp || !oitf_full);

  assign disp_o_alu_valid = disp_i_valid & cond;
  assign disp_i_ready     = cond & disp_o_alu_ready;
  assign wfi_halt_exu_ack = oitf_empty & ~amo_wait;

  assign disp_o_alu_rs1   = disp_i_rs1x0 ? '0 : disp_i_rs1;
  assign disp_o_alu_rs2   = disp_i_rs2x0 ? '0 : disp_i_rs2;
  assign disp_o_alu_imm   = disp_i_imm;
  assign disp_o_alu_rdwen = disp_i_rdwen;
  assign disp_o_alu_rdidx = disp_i_rdidx;
  assign disp_o_alu_info  = disp_i_info;
  assign disp_o_alu_pc    = disp_i_pc;
  assign disp_o_alu_itag  = alc_idx;

  assign oitf_ret_rdwen = ent_rdwen[ret_idx];
  assign oitf_ret_rdidx = ent_rdidx[ret_idx];
  assign oitf_ret_pc    = ent_pc[ret_idx];
  assign oitf_ret_itag  = ret_idx;

  assign alc_ena = disp_o_alu_valid & disp_o_alu_ready & disp_o_alu_longpipe;
  assign ret_ena = oitf_ret_ena & ~oitf_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alc_ptr   <= '0;
      ret_ptr   <= '0;
      ent_vld   <= '0;
      ent_rdwen <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ent_rdidx[k] <= '0;
        ent_pc[k]    <= '0;
      end
    end else begin
      if (ret_ena) begin
        ent_vld[ret_idx] <= 1'b0;
        ret_ptr          <= ret_ptr + 1'b1;
      end
      // Retire comes first so an allocation landing on the same slot wins.
      if (alc_ena) begin
        ent_vld[alc_idx]   <= 1'b1;
        ent_rdwen[alc_idx] <= disp_i_rdwen;
        ent_rdidx[alc_idx] <= disp_i_rdidx;
        ent_pc[alc_idx]    <= disp_i_pc;
        alc_ptr            <= alc_ptr + 1'b1;
      end
    end
  end

endmodule
